mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester port indices and the default access timeout.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the port that did not receive the previous grant.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Combinational pick; grant is only meaningful while valid is high
  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    if (&req) begin
      grant = ~last;
    end else if (req[PORT_DMA]) begin
      grant = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a cpu port and a dma port onto a single memory interface.
// One access at a time: the granted request is latched, the memory strobes
// are held until mem_ready or until TIMEOUT cycles pass, and the owner gets
// a one-cycle ack (with err on timeout) in the cycle after completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_adr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_ack,
  output logic             c_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_adr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             d_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic               last;
  logic               port;
  logic               we_reg;
  logic [WIDTH-1:0]   adr_reg;
  logic [WIDTH-1:0]   wdata_reg;
  logic [CNT_W-1:0]   cnt;
  logic               c_elig;
  logic               d_elig;
  logic               arb_grant;
  logic               arb_valid;
  logic               grant_evt;
  logic               done_ok;
  logic               done_to;

  // A requester still shows req during its own ack cycle; mask it out there
  assign c_elig = c_req & ~c_ack;
  assign d_elig = d_req & ~d_ack;

  arb_rr2 u_arb (
    .req   ({d_elig, c_elig}),
    .last  (last),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Next-state logic: grant from IDLE, finish on ready or on the last timeout cycle
  always_comb begin
    state_nxt = state;
    grant_evt = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_nxt = ACCESS;
          grant_evt = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_nxt = IDLE;
          done_ok   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_to   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any access in flight without an ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control: round-robin history, owner, timeout counter, ack/err pulses, read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      last    <= PORT_DMA;
      port    <= PORT_CPU;
      cnt     <= '0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_err   <= 1'b0;
      d_err   <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      c_ack <= (done_ok | done_to) & (port == PORT_CPU);
      d_ack <= (done_ok | done_to) & (port == PORT_DMA);
      c_err <= done_to & (port == PORT_CPU);
      d_err <= done_to & (port == PORT_DMA);
      if (grant_evt) begin
        last <= arb_grant;
        port <= arb_grant;
        cnt  <= '0;
      end else if (state == ACCESS && !mem_ready) begin
        cnt <= cnt + 1'b1;
      end
      if (done_ok && !we_reg) begin
        if (port == PORT_CPU) begin
          c_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  // Request capture at grant; requester inputs are ignored for the rest of the access
  always_ff @(posedge clk) begin
    if (grant_evt) begin
      we_reg    <= arb_grant ? d_we    : c_we;
      adr_reg   <= arb_grant ? d_adr   : c_adr;
      wdata_reg <= arb_grant ? d_wdata : c_wdata;
    end
  end

  assign mem_read  = (state == ACCESS) & ~we_reg;
  assign mem_write = (state == ACCESS) &  we_reg;
  assign mem_adr   = (state == ACCESS) ? adr_reg   : '0;
  assign mem_wdata = (state == ACCESS) ? wdata_reg : '0;

endmodule
